// File: rtl/sprite_motion_ctrl.sv
// Sprite overlay scheduler: tracks the raster from the blanking signals, bounces the sprite once per
// frame during vertical blank, steps the animation index and drives the per-pixel window/ROM address.
//
// state  | meaning
// IDLE   | overlay off, sprite parked at screen centre
// RUN    | overlay on, waiting for the start of vertical blank
// UPDATE | one cen cycle: apply motion step, advance animation hold counter
// PAUSE  | overlay on, motion and animation frozen
module sprite_motion_ctrl #(
   parameter int SPR_W      = 400,
   parameter int SPR_H      = 176,
   parameter int SCR_W      = 1920,
   parameter int SCR_H      = 1080,
   parameter int STEP_X     = 4,
   parameter int STEP_Y     = 2,
   parameter int N_FRAMES   = 8,
   parameter int FRAME_HOLD = 4
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        cen_i,
   input  logic [1:0]                  vh_blank_i,
   input  logic                        enable_i,
   input  logic                        pause_i,
   output logic [11:0]                 pos_x_o,
   output logic [11:0]                 pos_y_o,
   output logic [1:0]                  dir_o,
   output logic [$clog2(N_FRAMES)-1:0] anim_idx_o,
   output logic                        in_win_o,
   output logic [16:0]                 rom_addr_o,
   output logic                        frame_tick_o
);

   localparam int X_MAX = SCR_W - SPR_W;
   localparam int Y_MAX = SCR_H - SPR_H;
   localparam int AW    = $clog2(N_FRAMES);
   localparam int HW    = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_UPDATE, ST_PAUSE} state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [1:0]      r_blank_d;
   logic [11:0]     r_hcount;
   logic [11:0]     r_vcount;
   logic            r_h_ok;
   logic            r_v_ok;
   logic [11:0]     r_pos_x;
   logic [11:0]     r_pos_y;
   logic            r_dx_neg;
   logic            r_dy_neg;
   logic [AW-1:0]   r_anim;
   logic [HW-1:0]   r_hold;
   logic            r_in_win;
   logic [16:0]     r_rom_addr;
   logic [16:0]     r_addr_ctr;

   logic            w_hb_fall;
   logic            w_hb_rise;
   logic            w_vb_fall;
   logic            w_vb_rise;
   logic [12:0]     w_nx_sum;
   logic [12:0]     w_ny_sum;
   logic [11:0]     w_nx;
   logic [11:0]     w_ny;
   logic            w_ndx;
   logic            w_ndy;
   logic [12:0]     w_x_end;
   logic [12:0]     w_y_end;
   logic            w_active;
   logic            w_win;

   assign w_hb_fall = r_blank_d[0] & ~vh_blank_i[0];
   assign w_hb_rise = ~r_blank_d[0] & vh_blank_i[0];
   assign w_vb_fall = r_blank_d[1] & ~vh_blank_i[1];
   assign w_vb_rise = ~r_blank_d[1] & vh_blank_i[1];

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   if (enable_i) w_state_nxt = ST_RUN;
         ST_RUN: begin
            if (!enable_i)                   w_state_nxt = ST_IDLE;
            else if (w_vb_rise && !pause_i)  w_state_nxt = ST_UPDATE;
            else if (pause_i)                w_state_nxt = ST_PAUSE;
         end
         ST_UPDATE: w_state_nxt = ST_RUN;
         ST_PAUSE: begin
            if (!enable_i)     w_state_nxt = ST_IDLE;
            else if (!pause_i) w_state_nxt = ST_RUN;
         end
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   // 13-bit sums so the far-edge compare cannot wrap
   assign w_nx_sum = {1'b0, r_pos_x} + 13'(STEP_X);
   assign w_ny_sum = {1'b0, r_pos_y} + 13'(STEP_Y);

   always_comb begin
      w_nx  = r_pos_x;
      w_ndx = r_dx_neg;
      w_ny  = r_pos_y;
      w_ndy = r_dy_neg;
      if (!r_dx_neg) begin
         if (w_nx_sum >= 13'(X_MAX)) begin
            w_nx  = 12'(X_MAX);
            w_ndx = 1'b1;
         end else begin
            w_nx  = w_nx_sum[11:0];
         end
      end else if (r_pos_x <= 12'(STEP_X)) begin
         w_nx  = 12'd0;
         w_ndx = 1'b0;
      end else begin
         w_nx  = r_pos_x - 12'(STEP_X);
      end
      if (!r_dy_neg) begin
         if (w_ny_sum >= 13'(Y_MAX)) begin
            w_ny  = 12'(Y_MAX);
            w_ndy = 1'b1;
         end else begin
            w_ny  = w_ny_sum[11:0];
         end
      end else if (r_pos_y <= 12'(STEP_Y)) begin
         w_ny  = 12'd0;
         w_ndy = 1'b0;
      end else begin
         w_ny  = r_pos_y - 12'(STEP_Y);
      end
   end

   // Delayed blanks line up with the counter values they qualify
   assign w_x_end  = {1'b0, r_pos_x} + 13'(SPR_W);
   assign w_y_end  = {1'b0, r_pos_y} + 13'(SPR_H);
   assign w_active = (r_state != ST_IDLE) && enable_i;
   assign w_win    = w_active && r_h_ok && r_v_ok && (r_blank_d == 2'b00) &&
                     (r_hcount >= r_pos_x) && ({1'b0, r_hcount} < w_x_end) &&
                     (r_vcount >= r_pos_y) && ({1'b0, r_vcount} < w_y_end);

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_state    <= ST_IDLE;
         r_blank_d  <= 2'b00;
         r_hcount   <= 12'd0;
         r_vcount   <= 12'd0;
         r_h_ok     <= 1'b0;
         r_v_ok     <= 1'b0;
         r_pos_x    <= 12'(X_MAX / 2);
         r_pos_y    <= 12'(Y_MAX / 2);
         r_dx_neg   <= 1'b0;
         r_dy_neg   <= 1'b0;
         r_anim     <= '0;
         r_hold     <= '0;
         r_in_win   <= 1'b0;
         r_rom_addr <= 17'd0;
         r_addr_ctr <= 17'd0;
      end else if (cen_i) begin
         r_state   <= w_state_nxt;
         r_blank_d <= vh_blank_i;

         if (w_hb_fall)                r_hcount <= 12'd0;
         else if (r_hcount != 12'hFFF) r_hcount <= r_hcount + 12'd1;
         if (w_vb_fall)                          r_vcount <= 12'd0;
         else if (w_hb_rise && !vh_blank_i[1])   r_vcount <= r_vcount + 12'd1;
         if (w_hb_fall) r_h_ok <= 1'b1;
         if (w_vb_fall) r_v_ok <= 1'b1;

         if (w_state_nxt == ST_IDLE) begin
            r_pos_x  <= 12'(X_MAX / 2);
            r_pos_y  <= 12'(Y_MAX / 2);
            r_dx_neg <= 1'b0;
            r_dy_neg <= 1'b0;
            r_anim   <= '0;
            r_hold   <= '0;
         end else if (r_state == ST_UPDATE) begin
            r_pos_x  <= w_nx;
            r_pos_y  <= w_ny;
            r_dx_neg <= w_ndx;
            r_dy_neg <= w_ndy;
            if (r_hold == HW'(FRAME_HOLD - 1)) begin
               r_hold <= '0;
               r_anim <= r_anim + AW'(1);
            end else begin
               r_hold <= r_hold + HW'(1);
            end
         end

         r_in_win <= w_win;
         if (!w_active || w_vb_fall) begin
            r_rom_addr <= 17'd0;
            r_addr_ctr <= 17'd0;
         end else if (w_win) begin
            r_rom_addr <= r_addr_ctr;
            r_addr_ctr <= r_addr_ctr + 17'd1;
         end
      end
   end

   assign pos_x_o      = r_pos_x;
   assign pos_y_o      = r_pos_y;
   assign dir_o        = {r_dy_neg, r_dx_neg};
   assign anim_idx_o   = r_anim;
   assign in_win_o     = r_in_win;
   assign rom_addr_o   = r_rom_addr;
   assign frame_tick_o = (r_state == ST_UPDATE);

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed bench for sprite_motion_ctrl: full-size instance for motion, raster and control checks,
// plus a reduced-geometry instance to reach the last sprite pixel within a short run.
module tb_sprite_motion_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cen;
   logic [1:0]  vhb;
   logic        en;
   logic        en_s;
   logic        pause;

   logic [11:0] pos_x, pos_y, pos_x_s, pos_y_s;
   logic [1:0]  dir, dir_s;
   logic [2:0]  anim, anim_s;
   logic        in_win, in_win_s;
   logic [16:0] rom_addr, rom_addr_s;
   logic        tick, tick_s;

   logic        win_b  [0:4095];
   logic [16:0] addr_b [0:4095];
   logic        win_s  [0:4095];
   logic [16:0] addr_s [0:4095];

   int n_vec = 0;
   int n_err = 0;
   int tick_cnt = 0;
   int n_upd = 0;
   int t0;

   always #5 clk = ~clk;

   sprite_motion_ctrl u_dut (
      .clk_i(clk), .rst_i(rst_n), .cen_i(cen), .vh_blank_i(vhb), .enable_i(en), .pause_i(pause),
      .pos_x_o(pos_x), .pos_y_o(pos_y), .dir_o(dir), .anim_idx_o(anim), .in_win_o(in_win),
      .rom_addr_o(rom_addr), .frame_tick_o(tick)
   );

   sprite_motion_ctrl #(.SPR_W(8), .SPR_H(4), .SCR_W(32), .SCR_H(16)) u_dut_s (
      .clk_i(clk), .rst_i(rst_n), .cen_i(cen), .vh_blank_i(vhb), .enable_i(en_s), .pause_i(1'b0),
      .pos_x_o(pos_x_s), .pos_y_o(pos_y_s), .dir_o(dir_s), .anim_idx_o(anim_s), .in_win_o(in_win_s),
      .rom_addr_o(rom_addr_s), .frame_tick_o(tick_s)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input int p);
      @(posedge clk);
      #1;
      if (p >= 0 && p < 4096) begin
         win_b[p]  = in_win;
         addr_b[p] = rom_addr;
         win_s[p]  = in_win_s;
         addr_s[p] = rom_addr_s;
      end
      if (tick) tick_cnt++;
   endtask

   task automatic drive_line(input int n_act, input int n_blk, input logic vb);
      for (int p = 0; p < n_act; p++) begin
         vhb = {vb, 1'b0};
         step(p);
      end
      for (int q = 0; q < n_blk; q++) begin
         vhb = {vb, 1'b1};
         step(n_act + q);
      end
   endtask

   // log index p holds the outputs registered from hcount p-1
   task automatic row_checks(input int mode, input int k);
      case (mode)
         0: case (k)
               5:  check_val("s_above_win", win_s[13], 0);
               6: begin
                  check_val("s_left_out", win_s[12], 0);
                  check_val("s_first_win", win_s[13], 1);
                  check_val("s_first_addr", addr_s[13], 0);
               end
               9: begin
                  check_val("s_last_win", win_s[20], 1);
                  check_val("s_last_addr", addr_s[20], 31);
                  check_val("s_right_out", win_s[21], 0);
               end
               10: check_val("s_below_win", win_s[13], 0);
               default: ;
            endcase
         1: case (k)
               451: check_val("row451_win", win_b[761], 0);
               452: begin
                  check_val("h759_win", win_b[760], 0);
                  check_val("h760_win", win_b[761], 1);
                  check_val("h760_addr", addr_b[761], 0);
                  check_val("h1159_win", win_b[1160], 1);
                  check_val("h1159_addr", addr_b[1160], 399);
                  check_val("h1160_win", win_b[1161], 0);
                  check_val("h1160_addr_hold", addr_b[1161], 399);
               end
               453: check_val("row1_addr", addr_b[761], 400);
               454: begin
                  check_val("row2_addr", addr_b[761], 800);
                  check_val("row2_end_addr", addr_b[1160], 1199);
               end
               default: ;
            endcase
         2: if (k == 516) begin
               check_val("pause_win_in", win_b[889], 1);
               check_val("pause_win_left", win_b[888], 0);
            end
         default: ;
      endcase
   endtask

   task automatic drive_frame(input int n_rows, input int lo, input int hi, input int long_len, input int mode);
      for (int k = 0; k < n_rows; k++) begin
         if (k >= lo && k <= hi) begin
            drive_line(long_len, 4, 1'b0);
            row_checks(mode, k);
         end else begin
            drive_line(2, 2, 1'b0);
         end
      end
      drive_line(2, 2, 1'b1);
      drive_line(2, 2, 1'b1);
   endtask

   task automatic quick_frame();
      vhb = 2'b00; step(0); step(1);
      vhb = 2'b10; step(2); step(3); step(4);
   endtask

   task automatic cen_frame();
      vhb = 2'b00; step(0); step(1);
      cen = 1'b0; vhb = 2'b10;
      t0 = tick_cnt;
      step(2); step(3); step(4);
      check_val("cen_low_tick", tick_cnt - t0, 0);
      check_val("cen_low_x", pos_x, 1156);
      cen = 1'b1;
      step(5); step(6); step(7);
   endtask

   task automatic check_point(input int n);
      case (n)
         3:   check_val("anim_n3", anim, 0);
         4:   check_val("anim_n4", anim, 1);
         28:  check_val("anim_n28", anim, 7);
         31:  check_val("anim_n31", anim, 7);
         32: begin
            check_val("anim_wrap_n32", anim, 0);
            check_val("x_n32", pos_x, 888);
            check_val("y_n32", pos_y, 516);
         end
         33: begin
            check_val("resume_x", pos_x, 892);
            check_val("resume_y", pos_y, 518);
            check_val("resume_anim", anim, 0);
         end
         100: begin
            check_val("cen_resume_x", pos_x, 1160);
            check_val("cen_resume_y", pos_y, 652);
         end
         190: begin
            check_val("x_right_edge", pos_x, 1520);
            check_val("y_n190", pos_y, 832);
            check_val("dir_n190", dir, 2'b01);
         end
         191: check_val("x_bounce_left", pos_x, 1516);
         226: begin
            check_val("x_n226", pos_x, 1376);
            check_val("y_bottom_edge", pos_y, 904);
            check_val("dir_n226", dir, 2'b11);
         end
         227: check_val("y_bounce_up", pos_y, 902);
         570: begin
            check_val("x_left_edge", pos_x, 0);
            check_val("y_n570", pos_y, 216);
            check_val("dir_n570", dir, 2'b10);
         end
         571: begin
            check_val("x_bounce_right", pos_x, 4);
            check_val("y_n571", pos_y, 214);
            check_val("anim_n571", anim, 6);
         end
         default: ;
      endcase
   endtask

   initial begin
      rst_n = 1'b0; cen = 1'b1; vhb = 2'b11; en = 1'b0; en_s = 1'b0; pause = 1'b0;
      step(0); step(0);
      check_val("rst_x", pos_x, 760);
      check_val("rst_y", pos_y, 452);
      check_val("rst_dir", dir, 0);
      check_val("rst_anim", anim, 0);
      check_val("rst_win", in_win, 0);
      check_val("rst_addr", rom_addr, 0);
      check_val("rst_tick", tick, 0);
      check_val("rst_s_x", pos_x_s, 12);
      check_val("rst_s_y", pos_y_s, 6);
      rst_n = 1'b1;
      step(0);

      en_s = 1'b1;
      drive_frame(16, 0, 15, 32, 0);
      en_s = 1'b0;

      en = 1'b1;
      tick_cnt = 0;
      drive_frame(1080, 451, 454, 1920, 1);
      n_upd = 1;
      check_val("first_upd_x", pos_x, 764);
      check_val("first_upd_y", pos_y, 454);
      check_val("first_upd_dir", dir, 0);
      check_val("tick_width", tick_cnt, 1);

      while (n_upd < 571) begin
         if (n_upd == 99) cen_frame();
         else             quick_frame();
         n_upd++;
         check_point(n_upd);
         if (n_upd == 32) begin
            pause = 1'b1;
            t0 = tick_cnt;
            repeat (5) quick_frame();
            drive_frame(1080, 516, 516, 900, 2);
            check_val("pause_ticks", tick_cnt - t0, 0);
            check_val("pause_x", pos_x, 888);
            check_val("pause_y", pos_y, 516);
            check_val("pause_anim", anim, 0);
            pause = 1'b0;
         end
      end

      for (int k = 0; k < 214; k++) drive_line(2, 2, 1'b0);
      drive_line(10, 0, 1'b0);
      check_val("pre_dis_win", win_b[9], 1);
      en = 1'b0;
      step(10);
      check_val("dis_win", in_win, 0);
      check_val("dis_addr", rom_addr, 0);
      check_val("dis_x", pos_x, 760);
      check_val("dis_y", pos_y, 452);
      check_val("dis_dir", dir, 0);
      check_val("dis_anim", anim, 0);

      en = 1'b1;
      quick_frame();
      check_val("reen_x", pos_x, 764);
      for (int k = 0; k < 454; k++) drive_line(2, 2, 1'b0);
      drive_line(771, 0, 1'b0);
      check_val("pre_rst_win", win_b[770], 1);
      cen = 1'b0; rst_n = 1'b0;
      step(4095);
      check_val("mrst_x", pos_x, 760);
      check_val("mrst_y", pos_y, 452);
      check_val("mrst_dir", dir, 0);
      check_val("mrst_anim", anim, 0);
      check_val("mrst_win", in_win, 0);
      check_val("mrst_addr", rom_addr, 0);
      check_val("mrst_tick", tick, 0);
      rst_n = 1'b1; cen = 1'b1;
      repeat (5) step(4095);
      check_val("post_rst_win", in_win, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sprite_motion_ctrl.md
Name: sprite_motion_ctrl

Overview:
- Scheduler that sequences the centred-sprite overlay datapath in the video pipeline.
- Tracks the raster position from the blanking signals and moves the sprite once per frame, during vertical blank, bouncing off the screen edges.
- Steps an animation frame index.
- Per pixel, drives the sprite-window flag and the linear sprite-ROM read address consumed by the overlay/blend stage.

Parameters:
- SPR_W, 400, sprite width in pixels
- SPR_H, 176, sprite height in lines
- SCR_W, 1920, active screen width
- SCR_H, 1080, active screen height
- STEP_X, 4, horizontal pixels moved per frame
- STEP_Y, 2, vertical lines moved per frame
- N_FRAMES, 8, animation frames (power of two)
- FRAME_HOLD, 4, video frames per animation step

Ports:
- clk_i  in  1  video clock
- rst_i  in  1  reset, synchronous, active-low
- cen_i  in  1  video clock enable; all state advances only when high, except reset
- vh_blank_i  in  2  {Vblank, Hblank}
- enable_i  in  1  1 = overlay and motion active
- pause_i  in  1  1 = freeze motion and animation; overlay stays visible
- pos_x_o  out  12  sprite top-left X
- pos_y_o  out  12  sprite top-left Y
- dir_o  out  2  {dy_neg, dx_neg}
- anim_idx_o  out  $clog2(N_FRAMES)  current animation frame
- in_win_o  out  1  current pixel lies inside the sprite
- rom_addr_o  out  17  linear sprite address, row-major, 0..SPR_W*SPR_H-1
- frame_tick_o  out  1  one-cen pulse on each position update

Behaviour:
- Reset and clocking:
  - One clock domain.
  - rst_i low at any clk edge resets the block regardless of cen_i.
  - Reset values:
    - pos_x_o = (SCR_W-SPR_W)/2 = 760; pos_y_o = (SCR_H-SPR_H)/2 = 452
    - dir_o = 0 (moving right/down); anim_idx_o = 0; hold counter = 0
    - in_win_o = 0; rom_addr_o = 0; frame_tick_o = 0
    - state = IDLE; hcount = 0; vcount = 0
- Edge detection: registered delays of both blank bits give hb_fall, hb_rise, vb_fall, vb_rise.
- Raster counters:
  - hb_fall → hcount = 0; otherwise hcount+1, saturating at 4095.
  - vb_fall → vcount = 0. This has priority over a simultaneous hb_rise.
  - hb_rise with Vblank low → vcount+1.
- FSM states: IDLE, RUN, UPDATE, PAUSE.
  - IDLE: enable_i = 1 → RUN. Position stays parked at the reset centre.
  - RUN:
    - enable_i = 0 → IDLE. Position resets to centre, dir = 0, anim = 0.
    - vb_rise with pause_i = 0 → UPDATE.
    - pause_i = 1 → PAUSE.
  - UPDATE: lasts exactly one cen cycle, then returns to RUN.
    - Applies the motion step.
    - frame_tick_o = 1 for that cycle.
    - Advances the hold counter. When it reaches FRAME_HOLD-1 it clears and anim_idx increments, wrapping N_FRAMES-1 → 0.
  - PAUSE:
    - pause_i = 0 → RUN.
    - enable_i = 0 → IDLE.
    - No updates occur.
- Position changes only in UPDATE, which only happens inside vertical blank, so the image never tears.
- Motion step, X axis (Y identical, using STEP_Y and SCR_H-SPR_H = 904):
  - Moving right: nx = x+STEP_X.
    - If nx ≥ SCR_W-SPR_W (1520), then x = 1520 and dx_neg = 1.
  - Moving left:
    - If x ≤ STEP_X, then x = 0 and dx_neg = 0.
    - Otherwise x = x-STEP_X.
  - Both axes update in the same cycle.
  - Intermediate sums are 13 bits, so there is no wrap.
- Window and address, registered with 1 cen latency relative to the hcount/vcount values:
  - in_win_o = 1 when all of these hold:
    - pos_x ≤ hcount < pos_x+SPR_W
    - pos_y ≤ vcount < pos_y+SPR_H
    - both blanks low
    - state ≠ IDLE
  - rom_addr_o is generated incrementally, with no multiplier:
    - Cleared at vb_fall.
    - Increments by 1 on each cen cycle where the window condition is true.
    - Holds otherwise.
    - It is therefore the address of the current in-window pixel and reaches SPR_W*SPR_H-1 = 70399 at the last pixel.
  - rom_addr_o and in_win_o are 0 in IDLE.
- Reset mid-frame: outputs return to reset values on the next clk edge. hcount and vcount realign at the next hb_fall and vb_fall. in_win_o stays 0 until then.
- enable_i = 0 mid-frame: in_win_o drops on the next cen cycle.

Test Plan:
- Reset, then enable_i = 1 and one vb_rise → pos_x_o = 764, pos_y_o = 454, frame_tick_o high for exactly 1 cen cycle, dir_o = 0.
- Force pos_x to 1518 moving right, then one update → pos_x_o = 1520 and dir_o[0] = 1. Next update → 1516.
- Force pos_x to 3 moving left, then one update → pos_x_o = 0 and dir_o[0] = 0. Check the Y bottom edge at 904 the same way.
- Full 1920x1080 frame with pos (760,452):
  - hcount 760 / vcount 452 → in_win_o = 1, rom_addr_o = 0.
  - hcount 1159 → rom_addr_o = 399; hcount 1160 → in_win_o = 0.
  - Next line first window pixel → 400.
  - Last window pixel → 70399.
- 32 frames with FRAME_HOLD = 4 → anim_idx_o steps every 4 ticks and wraps 7 → 0. Assert pause_i for 5 frames → position and anim_idx_o frozen, in_win_o still asserted; release → motion resumes from the frozen values.
- Pull rst_i low mid-line with cen_i = 0 → all outputs are reset values on the next clk. enable_i = 0 mid-window → in_win_o = 0 on the next cen and position returns to (760,452).
